// File: rtl/axi_pkg.sv
// axi_pkg: shared state encoding and AXI read constants for the read arbiter
package axi_pkg;
  typedef enum logic [1:0] {ST_IDLE, ST_AR, ST_R} state_e;
  localparam logic [2:0] RD_TYPE_LINE   = 3'b100;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [2:0] AXI_SIZE_WORD  = 3'b010;
  localparam logic [3:0] ID_I_DEF       = 4'd0;
  localparam logic [3:0] ID_D_DEF       = 4'd1;
endpackage

// File: rtl/rd_arb_grant.sv
// rd_arb_grant: 2-requester one-hot grant (bit1 dcache); RD_ARB_RR_EN selects round-robin, else dcache fixed priority
module rd_arb_grant (
`ifdef RD_ARB_RR_EN
  input  logic       aclk,
  input  logic       aresetn,
  input  logic       take,
`endif
  input  logic [1:0] req,
  output logic [1:0] gnt
);
`ifdef RD_ARB_RR_EN
  logic last_d_q, last_d_d;
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) last_d_q <= 1'b0;
    else last_d_q <= last_d_d;
  always_comb begin
    gnt      = (&req) ? (last_d_q ? 2'b01 : 2'b10) : req;
    last_d_d = (take && |req) ? gnt[1] : last_d_q;
  end
`else
  assign gnt = req[1] ? 2'b10 : req;
`endif
endmodule

// File: rtl/axi_rd_arbiter.sv
// axi_rd_arbiter: shares one AXI AR/R channel between icache and dcache refills; RD_ARB_RR_EN enables round-robin grant
module axi_rd_arbiter
  import axi_pkg::*;
#(
  parameter int          ADDR_W    = 32,
  parameter int          BURST_LEN = 4,
  parameter logic [3:0]  ID_I      = ID_I_DEF,
  parameter logic [3:0]  ID_D      = ID_D_DEF
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic              i_rd_req,
  input  logic [2:0]        i_rd_type,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic              i_rd_rdy,
  output logic              i_ret_valid,
  output logic              i_ret_last,
  output logic [31:0]       i_ret_data,
  input  logic              d_rd_req,
  input  logic [2:0]        d_rd_type,
  input  logic [ADDR_W-1:0] d_rd_addr,
  output logic              d_rd_rdy,
  output logic              d_ret_valid,
  output logic              d_ret_last,
  output logic [31:0]       d_ret_data,
  output logic [3:0]        arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,
  input  logic [3:0]        rid,
  input  logic [31:0]       rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready,
  output logic              rd_err
);
  localparam logic [ADDR_W-1:0] LINE_MASK = ADDR_W'(BURST_LEN * 4 - 1);
  state_e              state_q, state_d;
  logic [3:0]          id_q, id_d, cnt_q, cnt_d;
  logic [ADDR_W-1:0]   addr_q, addr_d, sel_addr;
  logic [7:0]          len_q, len_d;
  logic [2:0]          size_q, size_d, sel_type;
  logic                own_d_q, own_d_d, err_q, err_d, hit, is_line;
  logic [1:0]          gnt;
  logic                unused;
  rd_arb_grant u_grant (
`ifdef RD_ARB_RR_EN
    .aclk    (aclk),
    .aresetn (aresetn),
    .take    (state_q == ST_IDLE),
`endif
    .req     ({d_rd_req, i_rd_req}),
    .gnt     (gnt)
  );
  always_ff @(posedge aclk or negedge aresetn)
    if (!aresetn) begin
      state_q <= ST_IDLE;
      id_q    <= ID_I;
      addr_q  <= '0;
      len_q   <= '0;
      size_q  <= '0;
      cnt_q   <= '0;
      own_d_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      addr_q  <= addr_d;
      len_q   <= len_d;
      size_q  <= size_d;
      cnt_q   <= cnt_d;
      own_d_q <= own_d_d;
      err_q   <= err_d;
    end
  always_comb begin
    sel_type = gnt[1] ? d_rd_type : i_rd_type;
    sel_addr = gnt[1] ? d_rd_addr : i_rd_addr;
    is_line  = sel_type == RD_TYPE_LINE;
    hit      = state_q == ST_R && rvalid && rid == id_q;
    state_d  = state_q;
    id_d     = id_q;
    addr_d   = addr_q;
    len_d    = len_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    own_d_d  = own_d_q;
    err_d    = err_q;
    if (state_q == ST_IDLE && |gnt) begin
      state_d = ST_AR;
      own_d_d = gnt[1];
      id_d    = gnt[1] ? ID_D : ID_I;
      addr_d  = is_line ? sel_addr & ~LINE_MASK : sel_addr;
      len_d   = is_line ? 8'(BURST_LEN - 1) : 8'd0;
      size_d  = is_line ? AXI_SIZE_WORD : {1'b0, sel_type[1:0]};
    end
    if (state_q == ST_AR && arready) begin
      state_d = ST_R;
      cnt_d   = '0;
    end
    // beat count is checked against arlen at rlast; mismatching IDs are dropped but flagged
    if (state_q == ST_R && rvalid) begin
      cnt_d   = hit ? cnt_q + 4'd1 : cnt_q;
      err_d   = err_q | !hit | (rlast && hit && cnt_q != len_q[3:0]);
      state_d = (hit && rlast) ? ST_IDLE : ST_R;
    end
  end
  assign arvalid     = state_q == ST_AR;
  assign rready      = state_q == ST_R;
  assign arid        = id_q;
  assign araddr      = addr_q;
  assign arlen       = len_q;
  assign arsize      = size_q;
  assign arburst     = AXI_BURST_INCR;
  assign i_rd_rdy    = arvalid & arready & !own_d_q;
  assign d_rd_rdy    = arvalid & arready & own_d_q;
  assign i_ret_valid = hit & !own_d_q;
  assign d_ret_valid = hit & own_d_q;
  assign i_ret_last  = hit & !own_d_q & rlast;
  assign d_ret_last  = hit & own_d_q & rlast;
  assign i_ret_data  = rdata;
  assign d_ret_data  = rdata;
  assign rd_err      = err_q;
  assign unused      = ^rresp;
endmodule

// File: tb/tb_axi_rd_arbiter.sv
// tb_axi_rd_arbiter: directed and randomized checks of axi_rd_arbiter against a transaction-level model
module tb_axi_rd_arbiter;
  localparam int BL = 4;
  localparam logic [3:0] IDI = 4'd0, IDD = 4'd1;
  logic aclk = 0, aresetn = 0;
  logic i_rd_req = 0, d_rd_req = 0;
  logic [2:0] i_rd_type = 0, d_rd_type = 0;
  logic [31:0] i_rd_addr = 0, d_rd_addr = 0;
  logic i_rd_rdy, i_ret_valid, i_ret_last, d_rd_rdy, d_ret_valid, d_ret_last;
  logic [31:0] i_ret_data, d_ret_data;
  logic [3:0] arid;
  logic [31:0] araddr;
  logic [7:0] arlen;
  logic [2:0] arsize;
  logic [1:0] arburst;
  logic arvalid, rready, rd_err;
  logic arready = 0, rlast = 0, rvalid = 0;
  logic [3:0] rid = 0;
  logic [31:0] rdata = 0;
  logic [1:0] rresp = 0;
  int pass_cnt = 0, total_cnt = 0;
  bit s_active = 0;
  logic [3:0] s_id = 0;
  int s_left = 0;
  int m_phase = 0, m_beats = 0;
  logic [3:0] m_id;
  logic [31:0] m_addr;
  logic [7:0] m_len;
  logic [2:0] m_size;
  bit m_own_d = 0, m_err = 0, m_last_d = 0;

  always #5 aclk = ~aclk;

  axi_rd_arbiter #(.ADDR_W(32), .BURST_LEN(BL)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .i_rd_req(i_rd_req), .i_rd_type(i_rd_type), .i_rd_addr(i_rd_addr), .i_rd_rdy(i_rd_rdy),
    .i_ret_valid(i_ret_valid), .i_ret_last(i_ret_last), .i_ret_data(i_ret_data),
    .d_rd_req(d_rd_req), .d_rd_type(d_rd_type), .d_rd_addr(d_rd_addr), .d_rd_rdy(d_rd_rdy),
    .d_ret_valid(d_ret_valid), .d_ret_last(d_ret_last), .d_ret_data(d_ret_data),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .rd_err(rd_err)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
  endtask

  // transaction-level model: one outstanding read, phase idle/address/data
  always @(negedge aclk) begin
    bit mt, od, line;
    logic [2:0] typ;
    logic [31:0] a;
    if (!aresetn) begin
      m_phase = 0; m_err = 0; m_last_d = 0;
    end else begin
      mt = m_phase == 2 && rvalid && rid == m_id;
      chk("arvalid", arvalid, m_phase == 1);
      if (m_phase == 1) begin
        chk("arid", arid, m_id);
        chk("araddr", araddr, m_addr);
        chk("arlen", arlen, m_len);
        chk("arsize", arsize, m_size);
        chk("arburst", arburst, 2'b01);
      end
      chk("rready", rready, m_phase == 2);
      chk("i_rd_rdy", i_rd_rdy, m_phase == 1 && arready && !m_own_d);
      chk("d_rd_rdy", d_rd_rdy, m_phase == 1 && arready && m_own_d);
      chk("i_ret_valid", i_ret_valid, mt && !m_own_d);
      chk("d_ret_valid", d_ret_valid, mt && m_own_d);
      chk("i_ret_last", i_ret_last, mt && !m_own_d && rlast);
      chk("d_ret_last", d_ret_last, mt && m_own_d && rlast);
      if (mt) chk("ret_data", m_own_d ? d_ret_data : i_ret_data, rdata);
      chk("rd_err", rd_err, m_err);
      if (m_phase == 0) begin
        if (i_rd_req || d_rd_req) begin
`ifdef RD_ARB_RR_EN
          od = d_rd_req && (!i_rd_req || !m_last_d);
`else
          od = d_rd_req;
`endif
          m_last_d = od;
          m_own_d = od;
          typ = od ? d_rd_type : i_rd_type;
          a = od ? d_rd_addr : i_rd_addr;
          line = typ == 3'b100;
          m_id = od ? IDD : IDI;
          m_addr = line ? a - a % (BL * 4) : a;
          m_len = line ? 8'(BL - 1) : 8'd0;
          m_size = line ? 3'd2 : {1'b0, typ[1:0]};
          m_phase = 1;
        end
      end else if (m_phase == 1) begin
        if (arready) begin m_phase = 2; m_beats = 0; end
      end else if (rvalid) begin
        if (rid == m_id) begin
          m_beats++;
          if (rlast) begin
            if (m_beats != m_len + 1) m_err = 1;
            m_phase = 0;
          end
        end else m_err = 1;
      end
    end
  end

  task automatic do_reset();
    i_rd_req = 0; d_rd_req = 0; arready = 0; rvalid = 0; rlast = 0; s_active = 0;
    aresetn = 0;
    #1;
    chk("rst_arvalid", arvalid, 0);
    chk("rst_rready", rready, 0);
    chk("rst_rdy", {i_rd_rdy, d_rd_rdy}, 0);
    chk("rst_ret", {i_ret_valid, d_ret_valid, i_ret_last, d_ret_last}, 0);
    chk("rst_rd_err", rd_err, 0);
    chk("rst_arid", arid, IDI);
    chk("rst_ar_fields", {araddr, arlen, arsize}, 0);
    repeat (2) @(posedge aclk);
    #1 aresetn = 1;
  endtask

  task automatic serve(input logic [3:0] e_id, input logic [31:0] e_addr, input logic [7:0] e_len,
                       input logic [2:0] e_size, input int n, input bit with_last, input int bad_at,
                       input bit drop, input int ar_wait);
    bit seen = 0;
    bit own_d = e_id == IDD;
    for (int k = 0; k < 20 && !seen; k++) begin
      @(negedge aclk);
      seen = arvalid;
    end
    chk("ar_seen", seen, 1);
    if (!seen) return;
    chk("arid_lit", arid, e_id);
    chk("araddr_lit", araddr, e_addr);
    chk("arlen_lit", arlen, e_len);
    chk("arsize_lit", arsize, e_size);
    repeat (ar_wait) @(posedge aclk);
    @(posedge aclk); #1 arready = 1;
    @(negedge aclk);
    chk("rdy_lit", own_d ? d_rd_rdy : i_rd_rdy, 1);
    @(posedge aclk); #1 arready = 0;
    if (drop) begin
      if (own_d) d_rd_req = 0; else i_rd_req = 0;
    end
    @(negedge aclk);
    chk("rdy_pulse_lit", {i_rd_rdy, d_rd_rdy}, 0);
    @(posedge aclk); #1;
    for (int k = 0; k < n; k++) begin
      if (k == bad_at) begin
        rvalid = 1; rid = e_id ^ 4'd1; rlast = 0; rdata = 32'hdead_beef;
        @(negedge aclk);
        chk("bad_beat_dropped", {i_ret_valid, d_ret_valid}, 0);
        @(posedge aclk); #1;
      end
      rvalid = 1; rid = e_id; rdata = 32'ha0a0_0000 + k; rlast = with_last && k == n - 1;
      @(negedge aclk);
      chk("ret_valid_lit", own_d ? d_ret_valid : i_ret_valid, 1);
      chk("ret_data_lit", own_d ? d_ret_data : i_ret_data, 32'ha0a0_0000 + k);
      if (with_last && k == n - 1) chk("ret_last_lit", own_d ? d_ret_last : i_ret_last, 1);
      @(posedge aclk); #1;
    end
    rvalid = 0; rlast = 0;
  endtask

  task automatic rnd_req(input bit ok, inout logic req, inout logic [2:0] typ, inout logic [31:0] addr);
    if (ok || (req && $urandom_range(19) == 0)) req = 0;
    else if (!req && $urandom_range(2) == 0) begin
      req = 1;
      typ = $urandom_range(1) ? 3'b100 : 3'($urandom_range(2));
      addr = $urandom;
    end
  endtask

  task automatic run_random(input int n);
    bit i_ok, d_ok;
    for (int c = 0; c < n; c++) begin
      @(negedge aclk);
      i_ok = i_rd_rdy; d_ok = d_rd_rdy;
      if (arvalid && arready) begin s_active = 1; s_id = arid; s_left = arlen + 1; end
      else if (s_active && rvalid && rid == s_id) begin
        s_left--;
        if (rlast) s_active = 0;
      end
      @(posedge aclk); #1;
      if ($urandom_range(499) == 0) begin do_reset(); continue; end
      rnd_req(i_ok, i_rd_req, i_rd_type, i_rd_addr);
      rnd_req(d_ok, d_rd_req, d_rd_type, d_rd_addr);
      arready = $urandom_range(1);
      rresp = 2'($urandom);
      rdata = $urandom;
      if (s_active && $urandom_range(2) != 0) begin
        rvalid = 1;
        if ($urandom_range(15) == 0) begin rid = s_id ^ 4'd1; rlast = $urandom_range(1); end
        else begin rid = s_id; rlast = s_left == 1 || $urandom_range(23) == 0; end
      end else begin
        rvalid = 0; rid = 4'($urandom); rlast = $urandom_range(1);
      end
    end
  endtask

  initial begin
    logic [3:0] e;
    #2 do_reset();
    i_rd_type = 3'b100; i_rd_addr = 32'h1fc0_0014; i_rd_req = 1;
    serve(IDI, 32'h1fc0_0010, 8'd3, 3'd2, 4, 1, -1, 1, 1);
    @(negedge aclk);
    chk("idle_after_line", {arvalid, rready}, 0);
    @(posedge aclk); #1;
    i_rd_type = 3'b010; i_rd_addr = 32'h1000; d_rd_type = 3'b010; d_rd_addr = 32'h2004;
    i_rd_req = 1; d_rd_req = 1;
    for (int t = 0; t < 4; t++) begin
`ifdef RD_ARB_RR_EN
      e = (t % 2 == 0) ? IDD : IDI;
`else
      e = IDD;
`endif
      serve(e, e == IDD ? 32'h2004 : 32'h1000, 8'd0, 3'd2, 1, 1, -1, 0, 0);
    end
    d_rd_req = 0;
    serve(IDI, 32'h1000, 8'd0, 3'd2, 1, 1, -1, 1, 0);
    d_rd_type = 3'b000; d_rd_addr = 32'h8000_0003; d_rd_req = 1;
    serve(IDD, 32'h8000_0003, 8'd0, 3'd0, 1, 1, -1, 1, 0);
    d_rd_type = 3'b100; d_rd_addr = 32'h0000_2468; d_rd_req = 1;
    serve(IDD, 32'h0000_2460, 8'd3, 3'd2, 4, 1, 2, 1, 0);
    @(negedge aclk);
    chk("rd_err_bad_rid", rd_err, 1);
    @(posedge aclk); #1;
    i_rd_type = 3'b100; i_rd_addr = 32'h44; i_rd_req = 1;
    serve(IDI, 32'h40, 8'd3, 3'd2, 2, 0, -1, 1, 0);
    do_reset();
    i_rd_type = 3'b000; i_rd_addr = 32'h45; i_rd_req = 1;
    serve(IDI, 32'h45, 8'd0, 3'd0, 1, 1, -1, 1, 0);
    @(negedge aclk);
    chk("rd_err_after_reset", rd_err, 0);
    @(posedge aclk); #1;
    d_rd_type = 3'b100; d_rd_addr = 32'h100; d_rd_req = 1;
    serve(IDD, 32'h100, 8'd3, 3'd2, 3, 1, -1, 1, 0);
    @(negedge aclk);
    chk("rd_err_short_burst", rd_err, 1);
    chk("idle_after_short", rready, 0);
    @(posedge aclk); #1;
    run_random(4000);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end
endmodule
